imem_loader: RTL and testbench

Byte-stream program loader that writes 19-bit instruction words into the 4096-entry instruction memory's write port. It sits between a host byte channel (UART/debug bridge) and the memory, replacing reset-time preloading with runtime download. It holds the CPU in reset while a frame is in progress and reports completion and integrity errors.

---
 rtl/imem_loader_pkg.sv | 9 +
 rtl/imem_loader.sv | 94 +++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding, sync marker and memory geometry defaults
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_INSTR_W = 19;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA0, DATA1, DATA2, CSUM
  } loader_state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: byte-stream frame parser writing instruction words into imem
module imem_loader import imem_loader_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int INSTR_W = IMEM_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);
  loader_state_t state;
  logic [ADDR_W-1:0] addr;
  logic [11:0] cnt;
  logic [7:0] csum;
  logic [15:0] sh;
  logic xfer;
  assign xfer = in_valid && in_ready;
  // sh holds the last two accepted bytes: header high nibbles and B0/B1 of a word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      csum <= '0;
      sh <= '0;
      in_ready <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      wr_en <= 1'b0;
      done <= 1'b0;
      if (xfer) begin
        sh <= {sh[7:0], in_data};
        if (state != IDLE && state != CSUM) csum <= csum ^ in_data;
        case (state)
          IDLE: if (in_data == SYNC_BYTE) begin
            state <= ADDR_HI;
            csum <= '0;
            err <= 1'b0;
            cpu_hold <= 1'b1;
          end
          ADDR_HI: begin
            err <= err | (|in_data[7:4]);
            state <= ADDR_LO;
          end
          ADDR_LO: begin
            addr <= ADDR_W'({sh[3:0], in_data});
            state <= CNT_HI;
          end
          CNT_HI: begin
            err <= err | (|in_data[7:4]);
            state <= CNT_LO;
          end
          CNT_LO: begin
            cnt <= {sh[3:0], in_data};
            state <= ({sh[3:0], in_data} != 12'd0) ? DATA0 : CSUM;
          end
          DATA0: begin
            err <= err | (|in_data[7:INSTR_W-16]);
            state <= DATA1;
          end
          DATA1: state <= DATA2;
          DATA2: begin
            wr_en <= 1'b1;
            wr_addr <= addr;
            wr_data <= INSTR_W'({sh, in_data});
            addr <= addr + ADDR_W'(1);
            cnt <= cnt - 12'd1;
            state <= (cnt == 12'd1) ? CSUM : DATA0;
          end
          CSUM: begin
            err <= err | (csum != in_data);
            done <= 1'b1;
            cpu_hold <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked cycle by cycle against a frame-level model
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready, wr_en, cpu_hold, done, err;
  logic [11:0] wr_addr;
  logic [18:0] wr_data;

  imem_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_wr = 0;
  bit exp_ready = 0, exp_wr_en = 0, exp_hold = 0, exp_done = 0, exp_err = 0;
  logic [11:0] exp_wr_addr = '0;
  logic [18:0] exp_wr_data = '0;
  logic [18:0] dmem [0:4095];
  bit wrote [0:4095];
  logic [7:0] pay [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
    chk("wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
    chk("wr_data", 32'(wr_data), 32'(exp_wr_data));
    chk("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(exp_err));
    if (wr_en) begin
      dmem[wr_addr] = wr_data;
      wrote[wr_addr] = 1'b1;
      n_wr++;
    end
    if (done) n_done++;
  end

  task automatic step(input bit v, input logic [7:0] b, output bit x);
    bit r;
    in_valid = v;
    in_data = b;
    r = exp_ready;
    @(posedge clk);
    x = v && r;
    exp_ready = rst;
    exp_wr_en = 0;
    exp_done = 0;
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit x;
    int g;
    g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    repeat (g) step(1'b0, 8'h00, x);
    x = 0;
    for (int t = 0; t < 4 && !x; t++) step(1'b1, b, x);
    if (!x) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept: byte %h not taken within bound", b);
    end
  endtask

  // Expected outputs follow from each byte's position in the frame
  task automatic frame(input logic [7:0] ahi, alo, chi, clo, input bit flip, input int cut);
    logic [7:0] q[$];
    logic [7:0] cs;
    logic [11:0] base;
    logic [23:0] w;
    int n, last;
    n = int'({chi[3:0], clo});
    base = {ahi[3:0], alo};
    q.push_back(8'hA5); q.push_back(ahi); q.push_back(alo); q.push_back(chi); q.push_back(clo);
    for (int i = 0; i < 3 * n; i++) q.push_back(pay[i]);
    cs = 8'h00;
    for (int i = 1; i < q.size(); i++) cs ^= q[i];
    q.push_back(cs ^ {7'd0, flip});
    last = q.size() - 1;
    for (int p = 0; p <= last; p++) begin
      if (cut >= 0 && p > cut) break;
      send(q[p]);
      if (p == 0) begin exp_err = 0; exp_hold = 1; end
      if ((p == 1 || p == 3) && q[p][7:4] != 4'h0) exp_err = 1;
      if (p >= 5 && p < last) begin
        if ((p - 5) % 3 == 0 && q[p][7:3] != 5'h0) exp_err = 1;
        if ((p - 5) % 3 == 2) begin
          exp_wr_en = 1;
          exp_wr_addr = base + 12'((p - 5) / 3);
          w = {q[p-2], q[p-1], q[p]};
          exp_wr_data = w[18:0];
        end
      end
      if (p == last) begin exp_done = 1; exp_hold = 0; if (flip) exp_err = 1; end
    end
  endtask

  task automatic set_pay(input logic [7:0] b0, b1, b2, b3, b4, b5);
    pay[0] = b0; pay[1] = b1; pay[2] = b2; pay[3] = b3; pay[4] = b4; pay[5] = b5;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit x;
    int d0, w0, n;
    logic [7:0] ahi, chi;
    for (int i = 0; i < 4096; i++) begin dmem[i] = '0; wrote[i] = 1'b0; end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    step(1'b0, 8'h00, x);
    settle();
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    set_pay(8'h00, 8'h0C, 8'h26, 8'h02, 8'h30, 8'h0F);
    d0 = n_done;
    frame(8'h00, 8'h07, 8'h00, 8'h02, 1'b0, -1);
    settle();
    chk("basic_w7", 32'(dmem[7]), 32'h00C26);
    chk("basic_w8", 32'(dmem[8]), 32'h2300F);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_done", 32'(n_done - d0), 32'd1);

    set_pay(8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A);
    frame(8'h0F, 8'hFF, 8'h00, 8'h02, 1'b0, -1);
    settle();
    chk("wrap_w4095", 32'(dmem[4095]), 32'h12345);
    chk("wrap_w0", 32'(dmem[0]), 32'h6789A);
    chk("wrap_err", 32'(err), 32'd0);

    set_pay(8'h00, 8'h0C, 8'h26, 8'h02, 8'h30, 8'h0F);
    frame(8'h00, 8'h07, 8'h00, 8'h02, 1'b1, -1);
    settle();
    chk("badcs_err", 32'(err), 32'd1);

    set_pay(8'h80, 8'h12, 8'h34, 8'h03, 8'hFF, 8'hFF);
    frame(8'h00, 8'h20, 8'h10, 8'h02, 1'b0, -1);
    settle();
    chk("illegal_w20", 32'(dmem[12'h020]), 32'h01234);
    chk("illegal_w21", 32'(dmem[12'h021]), 32'h3FFFF);
    chk("illegal_err", 32'(err), 32'd1);

    d0 = n_done;
    w0 = n_wr;
    send(8'h11);
    send(8'h22);
    frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, -1);
    settle();
    chk("zero_writes", 32'(n_wr - w0), 32'd0);
    chk("zero_done", 32'(n_done - d0), 32'd1);
    chk("zero_err", 32'(err), 32'd0);

    set_pay(8'h01, 8'h11, 8'h11, 8'h02, 8'h22, 8'h22);
    pay[6] = 8'h03; pay[7] = 8'h33; pay[8] = 8'h33;
    frame(8'h01, 8'h00, 8'h00, 8'h03, 1'b0, 9);
    #2 rst = 1'b0;
    exp_ready = 0; exp_wr_en = 0; exp_wr_addr = '0; exp_wr_data = '0;
    exp_hold = 0; exp_done = 0; exp_err = 0;
    #1;
    chk("rst_now_ready", 32'(in_ready), 32'd0);
    chk("rst_now_hold", 32'(cpu_hold), 32'd0);
    chk("rst_now_addr", 32'(wr_addr), 32'd0);
    chk("rst_now_data", 32'(wr_data), 32'd0);
    repeat (3) step(1'b0, 8'h00, x);
    @(negedge clk);
    #1 rst = 1'b1;
    step(1'b0, 8'h00, x);
    chk("rst_word1_kept", 32'(wrote[12'h100]), 32'd1);
    chk("rst_word2_absent", 32'(wrote[12'h101]), 32'd0);

    set_pay(8'h00, 8'h0C, 8'h26, 8'h02, 8'h30, 8'h0F);
    frame(8'h02, 8'h00, 8'h00, 8'h02, 1'b0, -1);
    settle();
    chk("fresh_w200", 32'(dmem[12'h200]), 32'h00C26);
    chk("fresh_w201", 32'(dmem[12'h201]), 32'h2300F);
    chk("fresh_err", 32'(err), 32'd0);

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 8);
      for (int i = 0; i < 3 * n; i++)
        pay[i] = (i % 3 != 0) ? 8'($urandom) :
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      for (int k = $urandom_range(0, 2); k > 0; k--) send(8'($urandom_range(0, 8'hA4)));
      ahi = {($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0, 4'($urandom)};
      chi = {($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0, 4'h0};
      frame(ahi, 8'($urandom), chi, 8'(n), $urandom_range(0, 3) == 0, -1);
    end
    repeat (4) step(1'b0, 8'h00, x);
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
